// File: rtl/dmem_port_arbiter.sv
// Serialises the lane-A/B memory ops onto the single data_memory port and steers load data back.
// Optional DMEM_ARB_PERF_EN adds conflict_cnt_o, counting cycles that enter ISSUE_B.
module dmem_port_arbiter #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush_i,
    input  logic            req_a_i,
    input  logic [3:0]      we_a_i,
    input  logic [XLEN-1:0] addr_a_i,
    input  logic [XLEN-1:0] wdata_a_i,
    input  logic            req_b_i,
    input  logic [3:0]      we_b_i,
    input  logic [XLEN-1:0] addr_b_i,
    input  logic [XLEN-1:0] wdata_b_i,
    output logic            stall_o,
    output logic            rsp_valid_a_o,
    output logic            rsp_valid_b_o,
    output logic [XLEN-1:0] rsp_data_o,
`ifdef DMEM_ARB_PERF_EN
    output logic [31:0]     conflict_cnt_o,
`endif
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [3:0]      dmem_we,
    output logic            dmem_re,
    input  logic [XLEN-1:0] dmem_rdata
);

    localparam int unsigned HEAD = READ_LATENCY - 1;

    typedef enum logic {
        IDLE    = 1'b0,
        ISSUE_B = 1'b1
    } state_t;

    state_t            state;
    logic [3:0]        b_we;
    logic [XLEN-1:0]   b_addr;
    logic [XLEN-1:0]   b_wdata;
    logic [HEAD:0]     tag_valid;
    logic [HEAD:0]     tag_lane;

    logic              issue_valid;
    logic              issue_lane;
    logic [3:0]        issue_we;
    logic [XLEN-1:0]   issue_addr;
    logic [XLEN-1:0]   issue_wdata;
    logic              conflict;
    logic              push;

    // Port mux: the latched B owns the port in ISSUE_B, otherwise A has priority.
    always_comb begin
        issue_valid = 1'b0;
        issue_lane  = 1'b0;
        issue_we    = 4'h0;
        issue_addr  = '0;
        issue_wdata = '0;
        conflict    = 1'b0;
        if (!reset && !flush_i) begin
            if (state == ISSUE_B) begin
                issue_valid = 1'b1;
                issue_lane  = 1'b1;
                issue_we    = b_we;
                issue_addr  = b_addr;
                issue_wdata = b_wdata;
            end else if (req_a_i) begin
                issue_valid = 1'b1;
                issue_we    = we_a_i;
                issue_addr  = addr_a_i;
                issue_wdata = wdata_a_i;
                conflict    = req_b_i;
            end else if (req_b_i) begin
                issue_valid = 1'b1;
                issue_lane  = 1'b1;
                issue_we    = we_b_i;
                issue_addr  = addr_b_i;
                issue_wdata = wdata_b_i;
            end
        end
    end

    assign push       = issue_valid && (issue_we == 4'h0);
    assign stall_o    = conflict;
    assign dmem_addr  = issue_addr;
    assign dmem_wdata = issue_wdata;
    assign dmem_we    = issue_we;
    assign dmem_re    = push;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            b_we      <= 4'h0;
            b_addr    <= '0;
            b_wdata   <= '0;
            tag_valid <= '0;
            tag_lane  <= '0;
        end else begin
            if (state == ISSUE_B) begin
                state <= IDLE;
            end else if (conflict) begin
                state   <= ISSUE_B;
                b_we    <= we_b_i;
                b_addr  <= addr_b_i;
                b_wdata <= wdata_b_i;
            end
            // Tag pipe tracks in-flight loads; a flush kills everything in it.
            for (int i = 1; i < int'(READ_LATENCY); i++) begin
                tag_valid[i] <= tag_valid[i-1] && !flush_i;
                tag_lane[i]  <= tag_lane[i-1];
            end
            tag_valid[0] <= push;
            tag_lane[0]  <= issue_lane;
        end
    end

    assign rsp_valid_a_o = !reset && !flush_i && tag_valid[HEAD] && !tag_lane[HEAD];
    assign rsp_valid_b_o = !reset && !flush_i && tag_valid[HEAD] &&  tag_lane[HEAD];
    assign rsp_data_o    = (rsp_valid_a_o || rsp_valid_b_o) ? dmem_rdata : '0;

`ifdef DMEM_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            conflict_cnt_o <= 32'd0;
        end else if (conflict) begin
            conflict_cnt_o <= conflict_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Randomised scoreboard bench for dmem_port_arbiter with a behavioural memory and ordering model.
module tb_dmem_port_arbiter;

    localparam int unsigned XLEN = 32;
    localparam int unsigned RL   = 2;

    logic clk = 1'b0;
    logic reset = 1'b1, flush_i = 1'b0, req_a_i = 1'b0, req_b_i = 1'b0;
    logic [3:0] we_a_i = 4'h0, we_b_i = 4'h0;
    logic [XLEN-1:0] addr_a_i = '0, addr_b_i = '0, wdata_a_i = '0, wdata_b_i = '0;
    logic stall_o, rsp_valid_a_o, rsp_valid_b_o, dmem_re;
    logic [XLEN-1:0] rsp_data_o, dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0] dmem_we;
`ifdef DMEM_ARB_PERF_EN
    logic [31:0] conflict_cnt_o;
`endif

    always #5 clk = ~clk;

    dmem_port_arbiter #(.XLEN(XLEN), .READ_LATENCY(RL)) dut (
        .clk(clk), .reset(reset), .flush_i(flush_i),
        .req_a_i(req_a_i), .we_a_i(we_a_i), .addr_a_i(addr_a_i), .wdata_a_i(wdata_a_i),
        .req_b_i(req_b_i), .we_b_i(we_b_i), .addr_b_i(addr_b_i), .wdata_b_i(wdata_b_i),
        .stall_o(stall_o), .rsp_valid_a_o(rsp_valid_a_o), .rsp_valid_b_o(rsp_valid_b_o),
        .rsp_data_o(rsp_data_o),
`ifdef DMEM_ARB_PERF_EN
        .conflict_cnt_o(conflict_cnt_o),
`endif
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_we(dmem_we),
        .dmem_re(dmem_re), .dmem_rdata(dmem_rdata)
    );

    function automatic logic [31:0] init_word(input int i);
        return (i == 0) ? 32'hDEADBEEF : (32'h5A000000 ^ (32'(i) * 32'h00010203));
    endfunction

    // Synchronous data memory with RL-cycle read latency, reloaded during reset.
    logic [31:0] mem [64];
    logic [31:0] rd_pipe [RL];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
            for (int i = 0; i < int'(RL); i++) rd_pipe[i] <= 32'h0;
        end else begin
            for (int b = 0; b < 4; b++)
                if (dmem_we[b]) mem[dmem_addr[7:2]][8*b +: 8] <= dmem_wdata[8*b +: 8];
            rd_pipe[0] <= dmem_re ? mem[dmem_addr[7:2]] : 32'hBAD0BAD0;
            for (int i = 1; i < int'(RL); i++) rd_pipe[i] <= rd_pipe[i-1];
        end
    end
    assign dmem_rdata = rd_pipe[RL-1];

    typedef struct {
        bit          lane;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        q[$];
    logic [31:0] ref_mem [64];
    int          n_tests = 0, n_fail = 0, cyc = 0, conflicts = 0;
    bit          owed = 1'b0;
    logic [3:0]  owed_we;
    logic [31:0] owed_addr, owed_data;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // One op reaches the port: bus must carry it; loads owe a response RL cycles later.
    task automatic issue(input bit lane, input logic [3:0] we, input logic [31:0] a, input logic [31:0] d);
        check("bus_we", 64'(dmem_we), 64'(we));
        check("bus_re", 64'(dmem_re), 64'(we == 4'h0));
        check("bus_addr", 64'(dmem_addr), 64'(a));
        if (we != 4'h0) begin
            check("bus_wdata", 64'(dmem_wdata), 64'(d));
            for (int b = 0; b < 4; b++)
                if (we[b]) ref_mem[a[7:2]][8*b +: 8] = d[8*b +: 8];
        end else begin
            q.push_back('{lane: lane, data: ref_mem[a[7:2]], due: cyc + int'(RL)});
        end
    endtask

    task automatic no_issue();
        check("bus_idle", 64'({dmem_we, dmem_re}), 64'd0);
    endtask

    task automatic step(input bit rst, input bit fl, input bit ra, input bit rb,
                        input logic [3:0] wa, input logic [3:0] wb,
                        input logic [31:0] aa, input logic [31:0] ab,
                        input logic [31:0] da, input logic [31:0] db);
        bit exp_stall;
        @(posedge clk); #1;
        reset = rst; flush_i = fl; req_a_i = ra; req_b_i = rb;
        we_a_i = wa; we_b_i = wb; addr_a_i = aa; addr_b_i = ab; wdata_a_i = da; wdata_b_i = db;
        #2;
        exp_stall = 1'b0;
        if (rst) begin
            check("rst_outputs", 64'({dmem_we, dmem_re, stall_o, rsp_valid_a_o, rsp_valid_b_o}), 64'd0);
            owed = 1'b0;
            conflicts = 0;
            q.delete();
            for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        end else begin
            if (fl) while (q.size() > 0 && q[q.size()-1].due >= cyc) void'(q.pop_back());
            if (owed) begin
                owed = 1'b0;
                if (fl) no_issue();
                else issue(1'b1, owed_we, owed_addr, owed_data);
            end else if (fl) begin
                no_issue();
            end else if (ra) begin
                issue(1'b0, wa, aa, da);
                if (rb) begin
                    owed = 1'b1; owed_we = wb; owed_addr = ab; owed_data = db;
                    exp_stall = 1'b1;
                    conflicts++;
                end
            end else if (rb) begin
                issue(1'b1, wb, ab, db);
            end else begin
                no_issue();
            end
            check("stall", 64'(stall_o), 64'(exp_stall));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Response monitor: pops the scoreboard whenever a lane reports load data.
    always @(negedge clk) begin
        if (!reset) begin
            if (rsp_valid_a_o && rsp_valid_b_o) begin
                check("rsp_both_valid", 64'd1, 64'd0);
            end else if (rsp_valid_a_o || rsp_valid_b_o) begin
                if (q.size() == 0) begin
                    check("rsp_spurious", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("rsp_lane", 64'(rsp_valid_b_o), 64'(e.lane));
                    check("rsp_data", 64'(rsp_data_o), 64'(e.data));
                    check("rsp_cycle", 64'(cyc), 64'(e.due));
                end
            end else if (q.size() > 0 && q[0].due <= cyc) begin
                check("rsp_missing", 64'd0, 64'd1);
                void'(q.pop_front());
            end
        end
    end

    initial begin
        bit ra, rb, fl;
        logic [3:0] wa, wb;
        logic [31:0] aa, ab, da, db;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        // Lone A load of the 0xDEADBEEF word.
        step(0, 0, 1, 0, 4'h0, 0, 32'h100, 0, 0, 0);
        idle(RL + 1);
        // Store A then dependent load B at the same address.
        step(0, 0, 1, 1, 4'hF, 4'h0, 32'h40, 32'h40, 32'h11223344, 0);
        step(0, 0, 1, 1, 4'hF, 4'h0, 32'h40, 32'h40, 32'h11223344, 0);
        idle(RL + 1);
        // Conflict, then flush while B is owed.
        step(0, 0, 1, 1, 4'h0, 4'h0, 32'h10, 32'h14, 0, 0);
        step(0, 1, 1, 1, 4'h0, 4'h0, 32'h10, 32'h14, 0, 0);
        idle(RL + 1);
        // Two loads in one cycle, responses in order.
        step(0, 0, 1, 1, 4'h0, 4'h0, 32'h10, 32'h14, 0, 0);
        step(0, 0, 1, 1, 4'h0, 4'h0, 32'h10, 32'h14, 0, 0);
        idle(RL + 1);
        // Reset arriving while B store is owed.
        step(0, 0, 1, 1, 4'h0, 4'hF, 32'h20, 32'h24, 0, 32'hCAFEF00D);
        step(1, 0, 1, 1, 4'h0, 4'hF, 32'h20, 32'h24, 0, 32'hCAFEF00D);
        idle(2);
        // Random traffic; a stalled pair stays on the inputs for the next cycle.
        ra = 0; rb = 0; wa = 0; wb = 0; aa = 0; ab = 0; da = 0; db = 0;
        for (int n = 0; n < 600; n++) begin
            if (!owed) begin
                ra = 1'($urandom_range(0, 1));
                rb = 1'($urandom_range(0, 1));
                wa = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                wb = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                aa = $urandom & 32'h0000_003C;
                ab = $urandom & 32'h0000_003C;
                da = $urandom;
                db = $urandom;
            end
            fl = ($urandom_range(0, 15) == 0);
            step(0, fl, ra, rb, wa, wb, aa, ab, da, db);
        end
        idle(RL + 3);
        check("scoreboard_drained", 64'(q.size()), 64'd0);
`ifdef DMEM_ARB_PERF_EN
        check("conflict_cnt", 64'(conflict_cnt_o), 64'(conflicts));
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(1);
        check("conflict_cnt_reset", 64'(conflict_cnt_o), 64'd0);
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
